// File: rtl/mux_2x1.sv
// mux_2x1: two-lane data selector with optional
// output register and valid tracking.
module mux_2x1 #(
  parameter int DATA_W  = 1,
  parameter bit REG_OUT = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] dout,
  input  logic              sel,
  input  logic [2*DATA_W-1:0] din,
  input  logic              in_valid,
  output logic              out_valid
);

  logic [DATA_W-1:0] lane0;
  logic [DATA_W-1:0] lane1;
  logic [DATA_W-1:0] pick;

  assign lane0 = din[DATA_W-1:0];
  assign lane1 = din[2*DATA_W-1:DATA_W];

  // lane decode on sel
  always_comb begin
    pick = lane0;
    unique case (1'b1)
      !sel: pick = lane0;
      sel:  pick = lane1;
    endcase
  end

  if (REG_OUT) begin : g_reg
    // capture on valid, hold otherwise; reset wins
    always_ff @(posedge clk) begin
      if (rst) begin
        dout      <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          dout <= pick;
        end
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};
    assign dout      = pick;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_mux_2x1.sv
// tb_mux_2x1: directed checks of registered
// 1-bit and combinational 8-bit variants.
module tb_mux_2x1;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [1:0]  din;
  logic        in_valid;
  logic        dout;
  logic        out_valid;

  logic        sel8;
  logic [15:0] din8;
  logic        iv8;
  logic [7:0]  dout8;
  logic        ov8;

  int n_cmp;
  int n_bad;

  mux_2x1 #(.DATA_W(1), .REG_OUT(1)) u_reg (
    .clk      (clk),
    .rst      (rst),
    .dout     (dout),
    .sel      (sel),
    .din      (din),
    .in_valid (in_valid),
    .out_valid(out_valid)
  );

  mux_2x1 #(.DATA_W(8), .REG_OUT(0)) u_comb (
    .clk      (clk),
    .rst      (rst),
    .dout     (dout8),
    .sel      (sel8),
    .din      (din8),
    .in_valid (iv8),
    .out_valid(ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s,
                      input logic [1:0] d,
                      input logic [0:0] exp_d,
                      input string tag);
    sel = s;
    din = d;
    tick();
    check(tag, {7'd0, dout}, {7'd0, exp_d});
    check({tag, "_v"}, {7'd0, out_valid}, 8'd1);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    sel      = 1'b0;
    din      = 2'b11;
    in_valid = 1'b1;
    sel8     = 1'b0;
    din8     = 16'h0000;
    iv8      = 1'b0;

    tick();
    check("rst_dout", {7'd0, dout}, 8'd0);
    check("rst_ov", {7'd0, out_valid}, 8'd0);
    rst = 1'b0;

    step(1'b0, 2'b00, 1'b0, "s0_00");
    step(1'b0, 2'b01, 1'b1, "s0_01");
    step(1'b0, 2'b10, 1'b0, "s0_10");
    step(1'b0, 2'b11, 1'b1, "s0_11");

    step(1'b1, 2'b11, 1'b1, "s1_11");
    step(1'b1, 2'b10, 1'b1, "s1_10");
    step(1'b1, 2'b01, 1'b0, "s1_01");
    step(1'b1, 2'b00, 1'b0, "s1_00");

    step(1'b0, 2'b11, 1'b1, "t11_s0");
    step(1'b1, 2'b11, 1'b1, "t11_s1");
    step(1'b0, 2'b10, 1'b0, "t10_s0");
    #1;
    sel = 1'b1;
    #2;
    check("no_async_sel", {7'd0, dout}, 8'd0);
    tick();
    check("t10_s1", {7'd0, dout}, 8'd1);

    in_valid = 1'b0;
    sel      = 1'b0;
    din      = 2'b00;
    tick();
    check("hold_dout", {7'd0, dout}, 8'd1);
    check("hold_ov", {7'd0, out_valid}, 8'd0);

    in_valid = 1'b1;
    sel      = 1'b1;
    din      = 2'b10;
    rst      = 1'b1;
    tick();
    check("mid_rst_dout", {7'd0, dout}, 8'd0);
    check("mid_rst_ov", {7'd0, out_valid}, 8'd0);
    rst = 1'b0;
    #2;
    check("rst_release_async", {7'd0, dout}, 8'd0);
    tick();
    check("post_rst_dout", {7'd0, dout}, 8'd1);
    check("post_rst_ov", {7'd0, out_valid}, 8'd1);

    din8 = 16'hA53C;
    sel8 = 1'b0;
    #1;
    check("comb_sel0", dout8, 8'h3C);
    check("comb_ov0", {7'd0, ov8}, 8'd0);
    sel8 = 1'b1;
    iv8  = 1'b1;
    #1;
    check("comb_sel1", dout8, 8'hA5);
    check("comb_ov1", {7'd0, ov8}, 8'd1);
    din8 = 16'h00FF;
    #1;
    check("comb_din_chg", dout8, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
